// File: rtl/lane_tx_scheduler_if.sv
// Handshake bundle between the two packet sources, the scheduler and the striping block.
interface lane_tx_scheduler_if;
  logic [31:0] data0;
  logic        valid0;
  logic        last0;
  logic        ready0;
  logic [31:0] data1;
  logic        valid1;
  logic        last1;
  logic        ready1;
  logic [31:0] data_out;
  logic        valid_out;
  logic        skp_active;
  logic        busy;

  modport master (
    output data0, valid0, last0, data1, valid1, last1,
    input  ready0, ready1, data_out, valid_out, skp_active, busy
  );

  modport slave (
    input  data0, valid0, last0, data1, valid1, last1,
    output ready0, ready1, data_out, valid_out, skp_active, busy
  );
endinterface

// File: rtl/lane_tx_scheduler.sv
// Whole-packet round-robin scheduler for the two-lane striping datapath,
// with periodic SKP ordered-set insertion at packet boundaries.
//
// state  | meaning
// IDLE   | no grant, arbitrating every cycle
// GRANT0 | source 0 owns the datapath until its last beat is accepted
// GRANT1 | source 1 owns the datapath until its last beat is accepted
// SKP    | emitting SKP_LEN SKP words, all requests held off
module lane_tx_scheduler #(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned SKP_LEN      = 4,
  parameter logic [31:0] SKP_WORD     = 32'h1C1C1C1C
) (
  input logic                clk_f,
  input logic                reset_L,
  lane_tx_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, SKP} state_t;

  localparam logic [15:0] CNT_MAX = 16'(SKP_INTERVAL - 1);
  localparam logic [3:0]  LEN     = 4'(SKP_LEN);

  state_t      state;
  state_t      state_nxt;
  logic        last_grant;
  logic [15:0] skp_cnt;
  logic        skp_pending;
  logic [3:0]  skp_left;
  logic [31:0] data_nxt;
  logic        valid_nxt;
  logic        skp_nxt;

  function automatic state_t pick(input logic pend, input logic v0, input logic v1,
                                  input logic lg);
    if (pend)          return SKP;
    if (v0 && v1)      return lg ? GRANT0 : GRANT1;
    if (v0)            return GRANT0;
    if (v1)            return GRANT1;
    return IDLE;
  endfunction

  assign bus.ready0 = (state == GRANT0);
  assign bus.ready1 = (state == GRANT1);

  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      skp_cnt     <= '0;
      skp_pending <= 1'b0;
      skp_left    <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == GRANT0)      last_grant <= 1'b0;
      else if (state_nxt == GRANT1) last_grant <= 1'b1;
      // SKP entry restarts the interval; otherwise the counter free-runs and saturates
      if (state_nxt == SKP && state != SKP) begin
        skp_cnt     <= '0;
        skp_pending <= 1'b0;
        skp_left    <= LEN;
      end else begin
        if (skp_cnt != CNT_MAX) skp_cnt <= skp_cnt + 16'd1;
        if (skp_cnt == CNT_MAX) skp_pending <= 1'b1;
        if (state == SKP)       skp_left <= skp_left - 4'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   state_nxt = pick(skp_pending, bus.valid0, bus.valid1, last_grant);
      GRANT0: if (bus.valid0 && bus.last0)
                state_nxt = pick(skp_pending, bus.valid0, bus.valid1, last_grant);
      GRANT1: if (bus.valid1 && bus.last1)
                state_nxt = pick(skp_pending, bus.valid0, bus.valid1, last_grant);
      SKP:    if (skp_left == 4'd1)
                state_nxt = pick(1'b0, bus.valid0, bus.valid1, last_grant);
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    data_nxt  = '0;
    valid_nxt = 1'b0;
    skp_nxt   = 1'b0;
    case (state)
      GRANT0: if (bus.valid0) begin
                data_nxt  = bus.data0;
                valid_nxt = 1'b1;
              end
      GRANT1: if (bus.valid1) begin
                data_nxt  = bus.data1;
                valid_nxt = 1'b1;
              end
      SKP: begin
        data_nxt  = SKP_WORD;
        valid_nxt = 1'b1;
        skp_nxt   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      bus.data_out   <= '0;
      bus.valid_out  <= 1'b0;
      bus.skp_active <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.data_out   <= data_nxt;
      bus.valid_out  <= valid_nxt;
      bus.skp_active <= skp_nxt;
      bus.busy       <= (state_nxt != IDLE);
    end
  end
endmodule

// File: tb/tb_lane_tx_scheduler.sv
// Scoreboard bench: accepted beats are queued as expected output, popped when the scheduler emits them.
module tb_lane_tx_scheduler;
  localparam logic [31:0] SKP_W = 32'h1C1C1C1C;

  typedef struct {logic v; logic [31:0] d; logic l;} beat_t;
  typedef struct {logic [31:0] d; logic l;} exp_t;
  typedef struct {int k; logic [31:0] d; logic skp; int cyc;} log_t;

  logic clk_f   = 1'b0;
  logic reset_L = 1'b1;
  always #5 clk_f = ~clk_f;

  lane_tx_scheduler_if bus_a();
  lane_tx_scheduler_if bus_b();

  lane_tx_scheduler #(.SKP_INTERVAL(8), .SKP_LEN(2), .SKP_WORD(SKP_W)) dut_a (
    .clk_f(clk_f), .reset_L(reset_L), .bus(bus_a));
  lane_tx_scheduler #(.SKP_INTERVAL(1000), .SKP_LEN(2), .SKP_WORD(SKP_W)) dut_b (
    .clk_f(clk_f), .reset_L(reset_L), .bus(bus_b));

  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  int    tgt = 0;
  beat_t src_q0[$];
  beat_t src_q1[$];
  exp_t  sb_a[$];
  exp_t  sb_b[$];
  log_t  log_q[$];
  log_t  sel_q[$];
  int    acc_src[$];
  int    acc0_n = 0;
  int    bb_mark = -1;
  int    bb_acc = -1;
  bit    in_pkt[2];
  int    skp_run[2];
  bit    rdy1_low_chk = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input int s, input logic v, input logic [31:0] d, input logic l);
    if (tgt == 0) begin
      if (s == 0) begin bus_a.valid0 = v; bus_a.data0 = d; bus_a.last0 = l; end
      else        begin bus_a.valid1 = v; bus_a.data1 = d; bus_a.last1 = l; end
    end else begin
      if (s == 0) begin bus_b.valid0 = v; bus_b.data0 = d; bus_b.last0 = l; end
      else        begin bus_b.valid1 = v; bus_b.data1 = d; bus_b.last1 = l; end
    end
  endtask

  function automatic logic rdy(input int s);
    if (tgt == 0) return (s == 0) ? bus_a.ready0 : bus_a.ready1;
    return (s == 0) ? bus_b.ready0 : bus_b.ready1;
  endfunction

  task automatic zero_inputs();
    bus_a.valid0 = 0; bus_a.data0 = '0; bus_a.last0 = 0;
    bus_a.valid1 = 0; bus_a.data1 = '0; bus_a.last1 = 0;
    bus_b.valid0 = 0; bus_b.data0 = '0; bus_b.last0 = 0;
    bus_b.valid1 = 0; bus_b.data1 = '0; bus_b.last1 = 0;
  endtask

  task automatic monitor(input int k);
    logic [31:0] d;
    logic        v, sk;
    exp_t        e;
    log_t        lg;
    d  = (k == 0) ? bus_a.data_out   : bus_b.data_out;
    v  = (k == 0) ? bus_a.valid_out  : bus_b.valid_out;
    sk = (k == 0) ? bus_a.skp_active : bus_b.skp_active;
    lg.k = k; lg.d = d; lg.skp = sk; lg.cyc = cyc;
    if (sk) begin
      check("skp_word", d, SKP_W);
      check("skp_valid", 32'(v), 32'd1);
      check("skp_inside_packet", 32'(in_pkt[k]), 32'd0);
      skp_run[k]++;
      log_q.push_back(lg);
    end else begin
      if (skp_run[k] != 0) begin
        check("skp_run_len", skp_run[k], 32'd2);
        skp_run[k] = 0;
      end
      if (v) begin
        if ((k == 0 && sb_a.size() == 0) || (k == 1 && sb_b.size() == 0)) begin
          check("spurious_word", 32'(v), 32'd0);
        end else begin
          if (k == 0) e = sb_a.pop_front();
          else        e = sb_b.pop_front();
          check("data", d, e.d);
          in_pkt[k] = !e.l;
          log_q.push_back(lg);
        end
      end else begin
        check("idle_data_zero", d, 32'd0);
      end
    end
  endtask

  task automatic step();
    beat_t b;
    exp_t  e;
    for (int s = 0; s < 2; s++) begin
      if ((s == 0 && src_q0.size() != 0) || (s == 1 && src_q1.size() != 0)) begin
        if (s == 0) b = src_q0[0];
        else        b = src_q1[0];
        drive(s, b.v, b.d, b.l);
        if (s == 1 && b.v && b.d == 32'hBB && bb_mark < 0) bb_mark = acc0_n;
        if (!b.v || rdy(s)) begin
          if (b.v) begin
            e.d = b.d; e.l = b.l;
            if (tgt == 0) sb_a.push_back(e);
            else          sb_b.push_back(e);
            acc_src.push_back(s);
            if (s == 0) acc0_n++;
            if (s == 1 && b.d == 32'hBB) bb_acc = acc0_n;
          end
          if (s == 0) void'(src_q0.pop_front());
          else        void'(src_q1.pop_front());
        end
      end else begin
        drive(s, 1'b0, '0, 1'b0);
      end
    end
    if (rdy1_low_chk) check("bubble_ready1", 32'(bus_a.ready1), 32'd0);
    @(posedge clk_f);
    #1;
    cyc++;
    monitor(0);
    monitor(1);
  endtask

  task automatic run(input string tag, input int budget);
    int n = 0;
    while ((src_q0.size() != 0 || src_q1.size() != 0 || sb_a.size() != 0 ||
            sb_b.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(src_q0.size() == 0 && src_q1.size() == 0 &&
                   sb_a.size() == 0 && sb_b.size() == 0), 32'd1);
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    #1;
    check("rst_data_out", bus_a.data_out, 32'd0);
    check("rst_valid_out", 32'(bus_a.valid_out), 32'd0);
    check("rst_skp_active", 32'(bus_a.skp_active), 32'd0);
    check("rst_busy", 32'(bus_a.busy), 32'd0);
    check("rst_ready", 32'({bus_a.ready1, bus_a.ready0}), 32'd0);
    zero_inputs();
    src_q0.delete(); src_q1.delete(); sb_a.delete(); sb_b.delete();
    log_q.delete(); acc_src.delete();
    acc0_n = 0; bb_mark = -1; bb_acc = -1;
    in_pkt[0] = 0; in_pkt[1] = 0; skp_run[0] = 0; skp_run[1] = 0;
    @(posedge clk_f);
    #1;
    reset_L = 1'b1;
    cyc = 0;
  endtask

  task automatic collect(input int k, input bit skp);
    sel_q.delete();
    foreach (log_q[i]) if (log_q[i].k == k && log_q[i].skp == skp) sel_q.push_back(log_q[i]);
  endtask

  function automatic beat_t bt(input logic v, input logic [31:0] d, input logic l);
    beat_t b;
    b.v = v; b.d = d; b.l = l;
    return b;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=%h exp=%h", cyc, 0);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tie_exp[6];
    int          c, i1;
    tie_exp = '{32'hA0, 32'hA1, 32'hA2, 32'hB0, 32'hB1, 32'hB2};
    zero_inputs();
    #2;

    // tie from reset on the long-interval instance
    tgt = 1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      src_q0.push_back(bt(1'b1, tie_exp[i], i == 2));
      src_q1.push_back(bt(1'b1, tie_exp[i + 3], i == 2));
    end
    run("tie_drain", 40);
    collect(1, 0);
    check("tie_count", sel_q.size(), 32'd6);
    for (int i = 0; i < 6 && i < sel_q.size(); i++) begin
      check("tie_data", sel_q[i].d, tie_exp[i]);
      check("tie_cycle", sel_q[i].cyc, 32'(2 + i));
    end

    // reset in the middle of a source 0 packet
    tgt = 0;
    do_reset();
    for (int i = 0; i < 4; i++) src_q0.push_back(bt(1'b1, 32'hA0 + 32'(i), i == 3));
    for (int n = 0; n < 20 && acc_src.size() < 2; n++) step();
    check("rst_mid_pre_valid", 32'(bus_a.valid_out), 32'd1);
    do_reset();
    src_q1.push_back(bt(1'b1, 32'hC0, 1'b0));
    src_q1.push_back(bt(1'b1, 32'hC1, 1'b1));
    run("rst_mid_drain", 20);
    for (int n = 0; n < 4; n++) step();
    collect(0, 0);
    check("rst_mid_count", sel_q.size(), 32'd2);
    if (sel_q.size() == 2) begin
      check("rst_mid_first", sel_q[0].d, 32'hC0);
      check("rst_mid_first_cyc", sel_q[0].cyc, 32'd2);
      check("rst_mid_second", sel_q[1].d, 32'hC1);
    end

    // fairness: source 0 streams single-beat packets, source 1 posts two
    do_reset();
    for (int i = 0; i < 10; i++) src_q0.push_back(bt(1'b1, 32'h01 + 32'(i), 1'b1));
    for (int i = 0; i < 3; i++) src_q1.push_back(bt(1'b0, '0, 1'b0));
    src_q1.push_back(bt(1'b1, 32'hBB, 1'b1));
    src_q1.push_back(bt(1'b1, 32'hBC, 1'b1));
    run("fair_drain", 80);
    check("fair_wait", 32'(bb_mark >= 0 && bb_acc >= 0 && bb_acc - bb_mark <= 2), 32'd1);
    i1 = -1;
    foreach (acc_src[i]) if (acc_src[i] == 1 && i1 < 0) i1 = i;
    check("fair_len", 32'(i1 >= 0 && i1 + 3 < acc_src.size()), 32'd1);
    if (i1 >= 0 && i1 + 3 < acc_src.size()) begin
      check("fair_alt1", acc_src[i1 + 1], 32'd0);
      check("fair_alt2", acc_src[i1 + 2], 32'd1);
      check("fair_alt3", acc_src[i1 + 3], 32'd0);
    end

    // bubble inside a source 0 packet
    do_reset();
    rdy1_low_chk = 1'b1;
    src_q0.push_back(bt(1'b1, 32'h10, 1'b0));
    src_q0.push_back(bt(1'b0, '0, 1'b0));
    src_q0.push_back(bt(1'b0, '0, 1'b0));
    src_q0.push_back(bt(1'b1, 32'h11, 1'b1));
    run("bubble_drain", 30);
    rdy1_low_chk = 1'b0;
    collect(0, 0);
    check("bubble_count", sel_q.size(), 32'd2);
    if (sel_q.size() == 2) begin
      check("bubble_first", sel_q[0].d, 32'h10);
      check("bubble_second", sel_q[1].d, 32'h11);
      check("bubble_gap", sel_q[1].cyc - sel_q[0].cyc, 32'd3);
    end

    // SKP deferred past a 12-word packet
    do_reset();
    src_q0.push_back(bt(1'b0, '0, 1'b0));
    for (int i = 0; i < 12; i++) src_q0.push_back(bt(1'b1, 32'h100 + 32'(i), i == 11));
    for (int n = 0; n < 6; n++) step();
    check("defer_busy", 32'(bus_a.busy), 32'd1);
    check("defer_ready0", 32'(bus_a.ready0), 32'd1);
    run("defer_drain", 40);
    for (int n = 0; n < 4; n++) step();
    collect(0, 0);
    check("defer_count", sel_q.size(), 32'd12);
    c = -100;
    if (sel_q.size() == 12) begin
      check("defer_first_cyc", sel_q[0].cyc, 32'd3);
      check("defer_contig", sel_q[11].cyc - sel_q[0].cyc, 32'd11);
      c = sel_q[11].cyc;
    end
    collect(0, 1);
    check("defer_skp_count", 32'(sel_q.size() >= 2), 32'd1);
    if (sel_q.size() >= 2) begin
      check("defer_skp_cyc0", sel_q[0].cyc, 32'(c + 1));
      check("defer_skp_cyc1", sel_q[1].cyc, 32'(c + 2));
    end

    // SKP insertion while idle
    do_reset();
    for (int n = 0; n < 24; n++) step();
    collect(0, 0);
    check("idle_no_data", sel_q.size(), 32'd0);
    collect(0, 1);
    check("idle_skp_count", sel_q.size(), 32'd4);
    if (sel_q.size() == 4) begin
      check("idle_skp_pos", 32'(sel_q[0].cyc >= 8 && sel_q[0].cyc <= 11), 32'd1);
      check("idle_skp_pair0", sel_q[1].cyc - sel_q[0].cyc, 32'd1);
      check("idle_skp_spacing",
            32'(sel_q[2].cyc - sel_q[0].cyc >= 8 && sel_q[2].cyc - sel_q[0].cyc <= 10), 32'd1);
      check("idle_skp_pair1", sel_q[3].cyc - sel_q[2].cyc, 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
